// File: rtl/peak_detect_if.sv
// peak_detect_if
//   Bundles the sample stream and the peak-result signals of peak_detect.
//   Signal names match the original peak_detect port names.
//
//   seq       : sample valid from the reorder stage
//   answer    : signed 8-bit serial spectrum sample (real bins 0..15, then imag 0..15)
//   peak_bin  : index of the largest-magnitude bin of the last completed frame
//   peak_mag  : r^2 + i^2 of peak_bin
//   done      : one-cycle pulse when peak_bin/peak_mag update
//   abort     : one-cycle pulse when a partial frame is dropped
//   busy      : high while a frame is being collected
//
//   master : producer of samples / consumer of results (testbench, upstream)
//   slave  : the peak detector itself
interface peak_detect_if;
    logic              seq;
    logic signed [7:0] answer;
    logic [3:0]        peak_bin;
    logic [15:0]       peak_mag;
    logic              done;
    logic              abort;
    logic              busy;

    modport master (
        output seq,
        output answer,
        input  peak_bin,
        input  peak_mag,
        input  done,
        input  abort,
        input  busy
    );

    modport slave (
        input  seq,
        input  answer,
        output peak_bin,
        output peak_mag,
        output done,
        output abort,
        output busy
    );
endinterface

// File: rtl/peak_detect.sv
// peak_detect
//   Collects one 32-sample spectrum frame (real bins 0..15 followed by
//   imaginary bins 0..15), computes r^2 + i^2 for each bin while the
//   imaginary half streams in, and reports the largest-magnitude bin.
//   Ties resolve to the lowest bin index. A gap in seq mid-frame drops the
//   frame and pulses abort; the previous result is held.
//
//   Parameters:
//     SKIP_DC   : 1 excludes bin 0 from the search
//     SEARCH_HI : highest bin searched (1..15)
//
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : peak_detect_if slave modport (seq, answer in; peak_bin, peak_mag,
//           done, abort, busy out)
module peak_detect #(
    parameter bit          SKIP_DC   = 1'b1,
    parameter int unsigned SEARCH_HI = 15
) (
    input  logic         clk,
    input  logic         rst,
    peak_detect_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REAL = 2'd1,
        IMAG = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Bit j set when bin j takes part in the search.
    localparam logic [15:0] HI_MASK     = 16'((32'd2 << SEARCH_HI) - 32'd1);
    localparam logic [15:0] DC_MASK     = SKIP_DC ? 16'hFFFE : 16'hFFFF;
    localparam logic [15:0] SEARCH_MASK = HI_MASK & DC_MASK;
    localparam logic [3:0]  FIRST_BIN   = SKIP_DC ? 4'd1 : 4'd0;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [7:0]  rbuf_q [16];
    logic [15:0]        max_mag_q, max_mag_d;
    logic [3:0]         max_bin_q, max_bin_d;
    logic [3:0]         peak_bin_q, peak_bin_d;
    logic [15:0]        peak_mag_q, peak_mag_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;

    logic [3:0]         k;
    logic signed [15:0] r_ext, i_ext;
    logic signed [15:0] sq_r, sq_i;
    logic [15:0]        mag;
    logic               imag_take;
    logic               last_sample;
    logic               take_max;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.seq) state_d = REAL;
            end
            REAL: begin
                if (!bus.seq)              state_d = IDLE;
                else if (cnt_q == 5'd15)   state_d = IMAG;
            end
            IMAG: begin
                if (!bus.seq)              state_d = IDLE;
                else if (cnt_q == 5'd31)   state_d = HOLD;
            end
            HOLD: begin
                if (!bus.seq) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (registered below so every output is a flop)
    // ------------------------------------------------------------------
    always_comb begin
        done_d  = 1'b0;
        abort_d = 1'b0;
        busy_d  = (state_d == REAL) || (state_d == IMAG);
        if ((state_q == IMAG) && bus.seq && (cnt_q == 5'd31)) begin
            done_d = 1'b1;
        end
        if (((state_q == REAL) || (state_q == IMAG)) && !bus.seq) begin
            abort_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Magnitude of the bin whose imaginary part is on the input now.
    // The low four bits of cnt are k = cnt - 16 while in IMAG.
    // ------------------------------------------------------------------
    always_comb begin
        k     = cnt_q[3:0];
        r_ext = 16'(rbuf_q[k]);
        i_ext = 16'(bus.answer);
        // 16-bit signed products are exact: the largest is (-128)^2 = 16384.
        sq_r  = r_ext * r_ext;
        sq_i  = i_ext * i_ext;
        mag   = $unsigned(sq_r) + $unsigned(sq_i);
    end

    // ------------------------------------------------------------------
    // Counter and running maximum
    // ------------------------------------------------------------------
    always_comb begin
        imag_take   = (state_q == IMAG) && bus.seq;
        last_sample = imag_take && (cnt_q == 5'd31);
        // First searched bin loads unconditionally; later ones need a
        // strictly larger magnitude, so the lowest index wins a tie.
        take_max    = imag_take && SEARCH_MASK[k] &&
                      ((k == FIRST_BIN) || (mag > max_mag_q));

        max_mag_d = take_max ? mag : max_mag_q;
        max_bin_d = take_max ? k   : max_bin_q;

        // The final sample's bin is folded in via max_*_d so the result
        // lands one cycle after the last imaginary sample.
        peak_bin_d = last_sample ? max_bin_d : peak_bin_q;
        peak_mag_d = last_sample ? max_mag_d : peak_mag_q;

        cnt_d = '0;
        case (state_q)
            IDLE:      cnt_d = bus.seq ? 5'd1 : 5'd0;
            REAL,
            IMAG:      cnt_d = bus.seq ? cnt_q + 5'd1 : 5'd0;
            default:   cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            max_mag_q  <= '0;
            max_bin_q  <= '0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            max_mag_q  <= max_mag_d;
            max_bin_q  <= max_bin_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
        end
    end

    // Real-part buffer: no reset needed, every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (bus.seq && ((state_q == IDLE) || (state_q == REAL))) begin
            rbuf_q[(state_q == IDLE) ? 4'd0 : cnt_q[3:0]] <= bus.answer;
        end
    end

    assign bus.peak_bin = peak_bin_q;
    assign bus.peak_mag = peak_mag_q;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_peak_detect.sv
// tb_peak_detect
//   Drives three peak_detect instances with the same sample stream:
//     dut_a : SKIP_DC=1, SEARCH_HI=15 (defaults)
//     dut_b : SKIP_DC=0, SEARCH_HI=15
//     dut_c : SKIP_DC=1, SEARCH_HI=9
//   Expected results come from a frame-level model that scans the stored
//   frame arrays with plain integer arithmetic.
module tb_peak_detect;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    peak_detect_if bus_a ();
    peak_detect_if bus_b ();
    peak_detect_if bus_c ();

    peak_detect #(.SKIP_DC(1'b1), .SEARCH_HI(15)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    peak_detect #(.SKIP_DC(1'b0), .SEARCH_HI(15)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    peak_detect #(.SKIP_DC(1'b1), .SEARCH_HI(9))  dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int n_checks = 0;
    int n_errors = 0;

    logic signed [7:0] fr_r [16];
    logic signed [7:0] fr_i [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic signed [7:0] a);
        bus_a.seq = s; bus_a.answer = a;
        bus_b.seq = s; bus_b.answer = a;
        bus_c.seq = s; bus_c.answer = a;
    endtask

    // Largest r^2+i^2 over the searched bins, lowest index on ties.
    function automatic void model(input bit skip, input int hi, output int bin, output int mag);
        bit found = 1'b0;
        bin = 0;
        mag = 0;
        for (int k = 0; k < 16; k++) begin
            int m;
            if (skip && k == 0) continue;
            if (k > hi) continue;
            m = int'(fr_r[k]) * int'(fr_r[k]) + int'(fr_i[k]) * int'(fr_i[k]);
            if (!found || m > mag) begin
                found = 1'b1;
                bin = k;
                mag = m;
            end
        end
    endfunction

    task automatic clear_frame();
        for (int k = 0; k < 16; k++) begin
            fr_r[k] = 8'sd0;
            fr_i[k] = 8'sd0;
        end
    endtask

    task automatic random_frame(input int mode);
        for (int k = 0; k < 16; k++) begin
            if (mode == 0) begin
                fr_r[k] = 8'($urandom_range(0, 255));
                fr_i[k] = 8'($urandom_range(0, 255));
            end else begin
                // Narrow range makes equal magnitudes common.
                fr_r[k] = 8'($signed($urandom_range(0, 6)) - 3);
                fr_i[k] = 8'($signed($urandom_range(0, 6)) - 3);
            end
        end
    endtask

    function automatic logic signed [7:0] sample(input int s);
        return (s < 16) ? fr_r[s] : fr_i[s - 16];
    endfunction

    task automatic check_results(input string tag);
        int bin, mag;
        model(1'b1, 15, bin, mag);
        check_eq({tag, ".a_done"}, 32'(bus_a.done), 32'd1);
        check_eq({tag, ".a_bin"},  32'(bus_a.peak_bin), 32'(bin));
        check_eq({tag, ".a_mag"},  32'(bus_a.peak_mag), 32'(mag));
        model(1'b0, 15, bin, mag);
        check_eq({tag, ".b_bin"},  32'(bus_b.peak_bin), 32'(bin));
        check_eq({tag, ".b_mag"},  32'(bus_b.peak_mag), 32'(mag));
        model(1'b1, 9, bin, mag);
        check_eq({tag, ".c_bin"},  32'(bus_c.peak_bin), 32'(bin));
        check_eq({tag, ".c_mag"},  32'(bus_c.peak_mag), 32'(mag));
    endtask

    // Full frame followed by one idle cycle.
    task automatic run_frame(input string tag);
        for (int s = 0; s < 32; s++) begin
            set_in(1'b1, sample(s));
            tick();
            if (s == 0)  check_eq({tag, ".busy"}, 32'(bus_a.busy), 32'd1);
            if (s == 30) check_eq({tag, ".early_done"}, 32'(bus_a.done), 32'd0);
        end
        check_results(tag);
        check_eq({tag, ".busy_after"}, 32'(bus_a.busy), 32'd0);
        set_in(1'b0, 8'sd0);
        tick();
        check_eq({tag, ".done_pulse"}, 32'(bus_a.done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int bin, mag;

        set_in(1'b0, 8'sd0);
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst.bin",   32'(bus_a.peak_bin), 32'd0);
        check_eq("rst.mag",   32'(bus_a.peak_mag), 32'd0);
        check_eq("rst.done",  32'(bus_a.done),     32'd0);
        check_eq("rst.abort", 32'(bus_a.abort),    32'd0);
        check_eq("rst.busy",  32'(bus_a.busy),     32'd0);
        rst = 1'b0;
        tick();

        // Single bin 5 peak, also checked against hand-computed values.
        clear_frame();
        fr_r[5] = 8'sd10;
        fr_i[5] = 8'sd3;
        run_frame("bin5");
        check_eq("bin5.const_bin", 32'(bus_a.peak_bin), 32'd5);
        check_eq("bin5.const_mag", 32'(bus_a.peak_mag), 32'd109);

        // Tie between bins 3 and 7.
        clear_frame();
        fr_r[3] = 8'sd20;
        fr_r[7] = -8'sd20;
        run_frame("tie");
        check_eq("tie.const_bin", 32'(bus_a.peak_bin), 32'd3);
        check_eq("tie.const_mag", 32'(bus_a.peak_mag), 32'd400);

        // Full-scale negative on both parts.
        random_frame(1);
        fr_r[2] = -8'sd128;
        fr_i[2] = -8'sd128;
        run_frame("fullscale");
        check_eq("fullscale.const_mag", 32'(bus_a.peak_mag), 32'd32768);

        // DC bin dominates only when it is searched.
        clear_frame();
        fr_r[0] = 8'sd100;
        fr_r[4] = 8'sd1;
        run_frame("dc");
        check_eq("dc.a_const_bin", 32'(bus_a.peak_bin), 32'd4);
        check_eq("dc.b_const_mag", 32'(bus_b.peak_mag), 32'd10000);

        // Completed frame, then a frame dropped after 20 samples.
        clear_frame();
        fr_r[5] = 8'sd10;
        fr_i[5] = 8'sd3;
        run_frame("pre_abort");
        random_frame(0);
        for (int s = 0; s < 20; s++) begin
            set_in(1'b1, sample(s));
            tick();
        end
        set_in(1'b0, 8'sd0);
        tick();
        check_eq("abort.pulse", 32'(bus_a.abort),    32'd1);
        check_eq("abort.done",  32'(bus_a.done),     32'd0);
        check_eq("abort.bin",   32'(bus_a.peak_bin), 32'd5);
        check_eq("abort.mag",   32'(bus_a.peak_mag), 32'd109);
        check_eq("abort.busy",  32'(bus_a.busy),     32'd0);
        tick();
        check_eq("abort.once",  32'(bus_a.abort),    32'd0);
        random_frame(0);
        run_frame("post_abort");

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            random_frame(f % 2);
            run_frame($sformatf("rand%0d", f));
        end

        // seq held high for 64 cycles: one frame, then HOLD ignores the rest.
        random_frame(0);
        model(1'b1, 15, bin, mag);
        done_cnt = 0;
        for (int s = 0; s < 64; s++) begin
            set_in(1'b1, (s < 32) ? sample(s) : 8'($urandom_range(0, 255)));
            tick();
            if (bus_a.done === 1'b1) done_cnt++;
        end
        check_eq("hold.done_count", 32'(done_cnt), 32'd1);
        check_eq("hold.bin", 32'(bus_a.peak_bin), 32'(bin));
        check_eq("hold.mag", 32'(bus_a.peak_mag), 32'(mag));
        set_in(1'b0, 8'sd0);
        tick();

        // Reset at sample 25 clears everything without abort or done.
        random_frame(0);
        for (int s = 0; s < 25; s++) begin
            set_in(1'b1, sample(s));
            tick();
        end
        set_in(1'b1, sample(25));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst.bin",   32'(bus_a.peak_bin), 32'd0);
        check_eq("midrst.mag",   32'(bus_a.peak_mag), 32'd0);
        check_eq("midrst.done",  32'(bus_a.done),     32'd0);
        check_eq("midrst.abort", 32'(bus_a.abort),    32'd0);
        check_eq("midrst.busy",  32'(bus_a.busy),     32'd0);
        done_cnt = 0;
        for (int s = 26; s < 32; s++) begin
            set_in(1'b1, sample(s));
            tick();
            if (bus_a.done === 1'b1) done_cnt++;
        end
        check_eq("midrst.no_done", 32'(done_cnt), 32'd0);
        set_in(1'b0, 8'sd0);
        tick();
        tick();

        // Reset on the cycle of the 32nd sample wins over completion.
        random_frame(0);
        run_frame("pre_lastrst");
        random_frame(0);
        for (int s = 0; s < 31; s++) begin
            set_in(1'b1, sample(s));
            tick();
        end
        set_in(1'b1, sample(31));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b0, 8'sd0);
        check_eq("lastrst.done", 32'(bus_a.done),     32'd0);
        check_eq("lastrst.mag",  32'(bus_a.peak_mag), 32'd0);
        tick();
        check_eq("lastrst.done_after", 32'(bus_a.done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
